// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Result is visible WIDTH cycles after accept; it is held in DONE until out_ready, and operands are refused meanwhile.
module mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_out_valid;
    logic                 r_busy;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_last;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign prod      = r_prod;

    // Magnitudes stay WIDTH-bit unsigned, so the most negative operand maps to 2^(WIDTH-1) exactly.
    assign w_a_mag = (signed_mode & a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (signed_mode & b[WIDTH-1]) ? -b : b;

    // Multiplicand shifts left and multiplier right each cycle, so bit 0 is always the current bit.
    assign w_pp   = r_mplier[0] ? r_mcand : '0;
    assign w_sum  = r_acc + w_pp;
    assign w_res  = r_neg ? -w_sum : w_sum;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_BUSY: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_prod      <= w_res;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Accept overrides the state decisions above, covering both IDLE and back-to-back DONE.
            if (w_accept) begin
                r_mcand     <= {{WIDTH{1'b0}}, w_a_mag};
                r_mplier    <= w_b_mag;
                r_neg       <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_acc       <= '0;
                r_cnt       <= '0;
                r_state     <= S_BUSY;
                r_busy      <= 1'b1;
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential integer multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or unsigned per operation, radix-2 shift-add at one multiplier bit per cycle. It is the area-optimised, handshaked successor to the team's fixed 4-bit combinational tree multiplier. It sits behind valid/ready streams so datapath blocks can issue multiplies without knowing the latency.

## Interface
- WIDTH, 8: operand width in bits, 2..32; product is 2*WIDTH bits.
- clk  in  1  rising-edge clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = a, b and prod are two's complement; 0 = unsigned. Sampled with a, b.
- out_valid  out  1  prod holds a finished result.
- out_ready  in  1  consumer takes prod this cycle.
- prod  out  2*WIDTH  product.
- busy  out  1  high in BUSY state.

## Operation
- States: IDLE, BUSY, DONE.
- Accept = in_valid & in_ready on a rising edge. a, b and signed_mode are captured at accept; later input changes have no effect.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from out_ready, no other input.
- IDLE -> BUSY on accept.
  - Capture |a| and |b| (magnitude only when signed_mode and the MSB is set) and neg = signed_mode & (a[MSB]^b[MSB]).
  - Clear accumulator and bit counter.
- BUSY, each edge:
  - If multiplier bit[count] = 1, add the multiplicand shifted by count into the 2*WIDTH accumulator.
  - count increments.
  - On the edge where count==WIDTH-1, write prod = neg ? -(acc+pp) : (acc+pp), truncated to 2*WIDTH, and go to DONE.
- DONE: out_valid=1 and prod is held stable until out_ready.
  - out_ready & in_valid: accept the new operands, DONE -> BUSY (back-to-back).
  - out_ready & !in_valid: DONE -> IDLE.
  - !out_ready: stay in DONE. Inputs are not accepted.
- Arithmetic:
  - Magnitudes are WIDTH-bit unsigned, so the most negative value (e.g. -128 at WIDTH=8) has magnitude 2^(WIDTH-1) and is exact.
  - All signed results fit in 2*WIDTH bits. No overflow or saturation exists.
- Zero operands still take the full WIDTH cycles. There is no early termination, so latency is fixed.
- prod keeps its last value in IDLE and BUSY. It is meaningful only while out_valid=1.

## Timing
- Reset values (asynchronous, immediate while rst=1):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0, prod = 0.
  - Internal accumulator and counter are 0.
- Reset mid-operation (BUSY or DONE): the result is discarded and never presented. The first edge after rst deasserts may accept.
- Latency: accept at edge E. out_valid is high after edge E+WIDTH, so WIDTH cycles from accept to the result being visible.
- Throughput with out_ready held high and in_valid continuous: one result per WIDTH+1 cycles, with no IDLE bubble.
- busy is high exactly for the WIDTH cycles between accept and out_valid.
- out_valid never drops without an out_ready handshake, except by reset.

## Test plan
- Unsigned, WIDTH=8: a=13, b=11, signed_mode=0 -> prod=0x008F (143). out_valid rises exactly 8 cycles after accept. busy is high for 8 cycles.
- Corners, WIDTH=8:
  - unsigned 255*255 -> 0xFE01
  - signed -3*5 -> 0xFFF1
  - signed -128*-128 -> 0x4000
  - signed -128*127 -> 0xC080
  - unsigned 0*200 -> 0x0000, still after 8 cycles
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and changing a/b.
  - prod stays stable; in_ready stays 0; no accept occurs.
  - Raising out_ready gives a handshake and accepts the next pair in the same cycle.
- Back-to-back stream: 4 pairs with in_valid and out_ready held high.
  - Results appear every 9 cycles, in order, each matching a*b.
- Reset mid-operation: assert rst 3 cycles into BUSY (7*9 in flight).
  - out_valid=0, prod=0, in_ready=1 immediately.
  - The next multiply, 6*6, returns 0x0024 with the normal latency.
- WIDTH=4 exhaustive: all 256 (a,b) pairs in both modes against a behavioural model of a*b (sign-extended in signed mode), with random out_ready stalls.
